// File: rtl/imem_pkg.sv
// Shared widths, the NOP word and the address range check for the instruction memory.
package imem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam logic [DATA_W_DEF-1:0] NOP_WORD = 16'h0000;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Load and fetch bus of the instruction memory; master is the loader/core side.
interface imem_fetch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;
    logic [ADDR_W:0]   load_count;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              stall;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              addr_fault;

    modport master (
        output load_en, load_addr, load_data, fetch_req, fetch_addr, stall,
        input  load_err, load_count, fetch_ready, instr_out, instr_valid, addr_fault
    );

    modport slave (
        input  load_en, load_addr, load_data, fetch_req, fetch_addr, stall,
        output load_err, load_count, fetch_ready, instr_out, instr_valid, addr_fault
    );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage with per-word written bits; synchronous write and read.
module imem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hit
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_hit_q, rd_hit_d;

    always_comb begin
        written_d = written_q;
        rd_hit_d  = rd_hit_q;
        rd_data_d = rd_data_q;
        if (wr_en) written_d[wr_idx] = 1'b1;
        if (rd_en) begin
            rd_hit_d  = written_q[rd_idx];
            rd_data_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            written_q <= written_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    // Storage is never reset; an edge seen while reset is held must not write.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_idx] <= wr_data;
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Writable instruction memory with a one-cycle registered fetch port, stall hold and fault flags.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input logic               clk,
    input logic               rst,
    imem_fetch_unit_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic              valid_q, valid_d;
    logic              range_q, range_d;
    logic              fetched_q, fetched_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              load_ok, fetch_ok, accept, hit;
    logic [DATA_W-1:0] rd_data;
    logic              rd_hit;

    assign bus.fetch_ready = !bus.load_en && !bus.stall;
    assign accept   = bus.fetch_req && bus.fetch_ready;
    assign load_ok  = bus.load_en && in_range(32'(bus.load_addr), DEPTH);
    assign fetch_ok = in_range(32'(bus.fetch_addr), DEPTH);

    always_comb begin
        valid_d      = valid_q;
        range_d      = range_q;
        fetched_d    = fetched_q;
        load_err_d   = bus.load_en && !load_ok;
        load_count_d = load_count_q;
        if (!bus.stall) begin
            valid_d = accept;
            if (accept) begin
                range_d   = fetch_ok;
                fetched_d = 1'b1;
            end
        end
        if (load_ok && load_count_q != CNT_MAX) load_count_d = load_count_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            range_q      <= 1'b0;
            fetched_q    <= 1'b0;
            load_err_q   <= 1'b0;
            load_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            range_q      <= range_d;
            fetched_q    <= fetched_d;
            load_err_q   <= load_err_d;
            load_count_q <= load_count_d;
        end
    end

    // The array read register only advances on an in-range accept, so it
    // holds through stalls and idle cycles together with range_q.
    imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load_ok),
        .wr_idx  (bus.load_addr[IDX_W-1:0]),
        .wr_data (bus.load_data),
        .rd_en   (accept && fetch_ok),
        .rd_idx  (bus.fetch_addr[IDX_W-1:0]),
        .rd_data (rd_data),
        .rd_hit  (rd_hit)
    );

    assign hit             = range_q && rd_hit;
    assign bus.instr_out   = hit ? rd_data : NOP_WORD;
    assign bus.addr_fault  = fetched_q && !hit;
    assign bus.instr_valid = valid_q;
    assign bus.load_err    = load_err_q;
    assign bus.load_count  = load_count_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed and randomized checks of imem_fetch_unit against a behavioural memory model.
module tb_imem_fetch_unit;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    imem_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NOP_WORD(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_wr  [DEPTH];
    logic [DW-1:0] m_instr;
    bit            m_valid, m_fault, m_err;
    int            m_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
        m_instr = 16'h0000;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    // One clock edge of the architectural behaviour, from the inputs held across it.
    task automatic m_clock();
        int fa;
        m_err = bus.load_en && (int'(bus.load_addr) >= DEPTH);
        if (bus.load_en && int'(bus.load_addr) < DEPTH) begin
            m_mem[bus.load_addr[7:0]] = bus.load_data;
            m_wr[bus.load_addr[7:0]]  = 1'b1;
            if (m_count < 65536) m_count++;
        end
        if (!bus.stall) begin
            if (bus.fetch_req && !bus.load_en) begin
                fa      = int'(bus.fetch_addr);
                m_valid = 1'b1;
                if (fa < DEPTH && m_wr[fa]) begin
                    m_instr = m_mem[fa];
                    m_fault = 1'b0;
                end else begin
                    m_instr = 16'h0000;
                    m_fault = 1'b1;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("instr_out",   32'(bus.instr_out),   32'(m_instr));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("addr_fault",  32'(bus.addr_fault),  32'(m_fault));
        chk("load_err",    32'(bus.load_err),    32'(m_err));
        chk("load_count",  32'(bus.load_count),  32'(m_count));
    endtask

    task automatic drv(input bit le, input logic [15:0] la, input logic [15:0] ld,
                       input bit fr, input logic [15:0] fa, input bit st);
        bus.load_en    = le;
        bus.load_addr  = la;
        bus.load_data  = ld;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.stall      = st;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 chk("fetch_ready", 32'(bus.fetch_ready), 32'(!bus.load_en && !bus.stall));
        @(posedge clk);
        m_clock();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit          le, fr, st;
        logic [15:0] la, ld, fa;

        drv(0, 0, 0, 0, 0, 0);
        m_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_instr", 32'(bus.instr_out),   32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_fault", 32'(bus.addr_fault),  32'h0);
        chk("rst_err",   32'(bus.load_err),    32'h0);
        chk("rst_count", 32'(bus.load_count),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // unwritten fetch
        drv(0, 0, 0, 1, 16'h0000, 0); step();
        chk("t1_instr", 32'(bus.instr_out),   32'h0);
        chk("t1_valid", 32'(bus.instr_valid), 32'h1);
        chk("t1_fault", 32'(bus.addr_fault),  32'h1);

        // load three words then fetch back-to-back
        drv(1, 16'h0000, 16'hc000, 0, 0, 0); step();
        drv(1, 16'h0001, 16'ha802, 0, 0, 0); step();
        drv(1, 16'h0002, 16'hc66b, 0, 0, 0); step();
        chk("t2_count", 32'(bus.load_count), 32'd3);
        drv(0, 0, 0, 1, 16'h0000, 0); step();
        chk("t2_w0", 32'(bus.instr_out), 32'hc000);
        chk("t2_f0", 32'(bus.addr_fault), 32'h0);
        drv(0, 0, 0, 1, 16'h0001, 0); step();
        chk("t2_w1", 32'(bus.instr_out), 32'ha802);
        drv(0, 0, 0, 1, 16'h0002, 0); step();
        chk("t2_w2", 32'(bus.instr_out), 32'hc66b);
        chk("t2_v2", 32'(bus.instr_valid), 32'h1);

        // out-of-range load and fetch
        drv(1, 16'h0100, 16'h1234, 0, 0, 0); step();
        chk("t3_err",   32'(bus.load_err),   32'h1);
        chk("t3_count", 32'(bus.load_count), 32'd3);
        drv(0, 0, 0, 0, 0, 0); step();
        chk("t3_err_drop", 32'(bus.load_err), 32'h0);
        drv(0, 0, 0, 1, 16'h0100, 0); step();
        chk("t3_instr", 32'(bus.instr_out),  32'h0);
        chk("t3_fault", 32'(bus.addr_fault), 32'h1);

        // stall holds the output
        drv(0, 0, 0, 1, 16'h0001, 0); step();
        chk("t4_pre", 32'(bus.instr_out), 32'ha802);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 1, 16'h0002, 1); step();
            chk("t4_hold",  32'(bus.instr_out),   32'ha802);
            chk("t4_holdv", 32'(bus.instr_valid), 32'h1);
        end
        drv(0, 0, 0, 1, 16'h0002, 0); step();
        chk("t4_post", 32'(bus.instr_out), 32'hc66b);

        // load beats fetch in the same cycle
        drv(1, 16'h0005, 16'h6895, 1, 16'h0005, 0);
        #1 chk("t5_ready", 32'(bus.fetch_ready), 32'h0);
        step();
        chk("t5_valid", 32'(bus.instr_valid), 32'h0);
        drv(0, 0, 0, 1, 16'h0005, 0); step();
        chk("t5_instr", 32'(bus.instr_out),   32'h6895);
        chk("t5_fault", 32'(bus.addr_fault),  32'h0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            le = ($urandom % 4) == 0;
            la = (($urandom % 8) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
            ld = 16'($urandom);
            fr = ($urandom % 10) < 7;
            fa = (($urandom % 8) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
            st = ($urandom % 4) == 0;
            drv(le, la, ld, fr, fa, st);
            step();
        end

        // asynchronous reset in the middle of a fetch
        drv(1, 16'h0001, 16'ha802, 0, 0, 0); step();
        drv(0, 0, 0, 1, 16'h0001, 0);
        @(posedge clk);
        m_clock();
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(bus.instr_valid), 32'h0);
        chk("t6_count", 32'(bus.load_count),  32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        drv(0, 0, 0, 1, 16'h0001, 0); step();
        chk("t6_instr", 32'(bus.instr_out),   32'h0);
        chk("t6_fault", 32'(bus.addr_fault),  32'h1);
        chk("t6_v",     32'(bus.instr_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised, writable instruction memory with a registered fetch port. It replaces the fixed combinational program ROM of the 16-bit Harvard core.
- Program words are written through a load port (boot loader or testbench) before or between runs.
- The core fetches through a request/valid handshake with stall support.
- Unwritten or out-of-range locations return the NOP word and raise a fault flag.
- Sits between the PC register and the instruction decoder.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 16, width of fetch and load addresses (PC width)
DEPTH, 256, number of storage words; must be <= 2**ADDR_W
NOP_WORD, 16'h0000, word returned for unwritten or out-of-range locations

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  write strobe for program loading
load_addr  in  ADDR_W  write address
load_data  in  DATA_W  write data
load_err  out  1  one-cycle pulse: last load_en had load_addr >= DEPTH
load_count  out  ADDR_W+1  number of accepted writes since reset, saturating
fetch_req  in  1  core requests the instruction at fetch_addr
fetch_addr  in  ADDR_W  PC value
fetch_ready  out  1  combinational: !load_en && !stall
stall  in  1  decoder back-pressure; holds output registers
instr_out  out  DATA_W  fetched instruction
instr_valid  out  1  instr_out holds a fetched word
addr_fault  out  1  qualifies instr_out: word came from out-of-range or unwritten location

Behaviour:
Reset values (asynchronous assertion, synchronous release):
- instr_out=NOP_WORD, instr_valid=0, addr_fault=0, load_err=0, load_count=0.
- All DEPTH per-word written bits are cleared.
- Storage array contents are not reset; they are masked by the written bits.

Load:
- On an edge with load_en=1 and load_addr < DEPTH: mem[load_addr] <= load_data, the written bit for that address is set, and load_count increments, saturating at 2**ADDR_W.
- load_addr >= DEPTH: no write, and load_err=1 for exactly one cycle. Back-to-back bad loads keep load_err high.
- Rewriting an address overwrites it and still increments load_count.

Fetch handshake:
- A fetch is accepted on an edge where fetch_req=1 and fetch_ready=1.
- Latency is 1 cycle: the result appears in instr_out with instr_valid=1 after the accepting edge.
- Result: mem[fetch_addr] if fetch_addr < DEPTH and its written bit is set; otherwise NOP_WORD with addr_fault=1.
- If stall=1, instr_out, instr_valid and addr_fault hold their values. The requester must hold fetch_req/fetch_addr until fetch_ready=1.
- If not stalled and no fetch is accepted (fetch_req=0, or load_en=1), instr_valid<=0. instr_out and addr_fault hold.

Priority and collisions:
- If load_en and fetch_req are both 1 in the same cycle, the load wins and the fetch is not accepted (fetch_ready=0).
- Read-during-write cannot occur.
- A fetch from an address loaded in the previous cycle returns the new data.
- Address wrap: none; fetch_addr >= DEPTH is a fault and is never folded modulo DEPTH.
- Reset mid-fetch: instr_valid drops immediately; the pending result is discarded.
- Reset mid-load: the write on that edge does not occur.

Control: no FSM beyond the valid/hold register. All outputs except fetch_ready are registered.

Decomposition:
Package imem_pkg:
- Default widths DATA_W=16 and ADDR_W=16.
- NOP_WORD constant.
- Function in_range(addr, depth).

Sub-module imem_array:
- DEPTH x DATA_W storage plus DEPTH written bits.
- Synchronous write, synchronous read.
- Reset port clears only the written bits.

Top level: handshake, stall hold, fault, load_err and load_count logic.

Test Plan:
- Reset, then fetch addr 0x0000 -> next cycle instr_out=16'h0000, instr_valid=1, addr_fault=1 (unwritten).
- Load 0x00=16'hc000, 0x01=16'ha802, 0x02=16'hc66b; fetch 0,1,2 back-to-back -> 16'hc000, 16'ha802, 16'hc66b on consecutive cycles, addr_fault=0, load_count=3.
- Load addr 0x0100 with DEPTH=256 -> load_err pulses 1 cycle, load_count unchanged. Then fetch 0x0100 -> NOP, addr_fault=1.
- Fetch addr 0x01 yielding 16'ha802, then assert stall for 3 cycles while fetch_addr=0x02 -> instr_out holds 16'ha802 with instr_valid=1. After stall drops, 16'hc66b appears 1 cycle later.
- Same cycle load_en (addr 0x05 = 16'h6895) and fetch_req (addr 0x05) -> fetch_ready=0, no accept, instr_valid=0 next. The repeated fetch returns 16'h6895.
- Assert rst asynchronously mid-stream -> instr_valid=0 immediately, load_count=0. Fetch of a previously loaded address returns NOP with addr_fault=1.
